lfsr_burst_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit Fibonacci LFSR (taps 7,5,4,3; shift toward MSB, feedback into bit 0). It accepts burst commands (seed, length, reseed flag) on a valid/ready port and emits the requested number of pseudo-random bytes on a valid/ready stream with backpressure. It also handles seeding, all-zero lockup avoidance, abort and end-of-burst signalling. It sits between stimulus/scrambler consumers and the LFSR datapath, which it owns and steps.

---
 rtl/lfsr_ctrl_pkg.sv | 17 +
 rtl/lfsr8_core.sv | 24 ++
 rtl/lfsr_burst_ctrl.sv | 79 +++++++
 tb/tb_lfsr_burst_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR burst controller.
//   state_t      : controller FSM states
//   LFSR_W       : LFSR register width
//   TAP_MASK     : Fibonacci taps 7,5,4,3
//   DEFAULT_SEED : reset value and replacement for an all-zero seed
//   lfsr_step()  : one shift toward the MSB, with feedback into bit 0
package lfsr_ctrl_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK     = 8'hB8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register.
//   clk, rst : clock, synchronous active-low reset (to SEED)
//   load     : load load_val (takes priority over step)
//   load_val : value to load
//   step     : advance one position
//   state    : current register contents
module lfsr8_core
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = lfsr_ctrl_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);
  always_ff @(posedge clk) begin
    if (!rst)      state <= SEED;
    else if (load) state <= load_val;
    else if (step) state <= lfsr_step(state);
  end
endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer around the 8-bit LFSR.
//   cmd_*      : burst command port (valid/ready); accepted only in IDLE
//   abort      : ends the running burst at the next edge
//   out_*      : pseudo-random byte stream with backpressure; out_last on
//                the final beat
//   busy/done  : FSM not idle / one-cycle end-of-command pulse
//   lfsr_state : live LFSR register
// Outputs decode registered state only; rst additionally forces them low
// while it is asserted (lfsr_state excepted).
module lfsr_burst_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int                CNT_W        = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = lfsr_ctrl_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LFSR_W-1:0] cmd_seed,
  input  logic              cmd_reseed,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] lfsr_state
);
  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic              cmd_hs, out_hs, last_beat;
  logic [LFSR_W-1:0] seed_eff;

  assign cmd_hs    = (state == IDLE) && cmd_valid;
  assign out_hs    = (state == RUN) && out_ready;
  assign last_beat = (remaining == CNT_W'(1));
  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff  = (cmd_seed == '0) ? DEFAULT_SEED : cmd_seed;

  lfsr8_core #(.SEED(DEFAULT_SEED)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_hs && cmd_reseed),
    .load_val (seed_eff),
    .step     (out_hs),
    .state    (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          remaining <= cmd_count;
          state     <= (cmd_count == '0) ? DONE : RUN;
        end
        RUN: begin
          if (out_ready) remaining <= remaining - CNT_W'(1);
          // A beat handshaked alongside abort still completes via out_hs.
          if (abort || (out_ready && last_beat)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = rst && (state == IDLE);
  assign out_valid = rst && (state == RUN);
  assign out_last  = rst && (state == RUN) && last_beat;
  assign busy      = rst && (state != IDLE);
  assign done      = rst && (state == DONE);
  assign out_data  = rst ? lfsr_state : '0;
endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
module tb_lfsr_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_seed = 8'h00;
  logic       cmd_reseed = 1'b0;
  logic [7:0] cmd_count = 8'h00;
  logic       abort = 1'b0;
  logic       out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [7:0] out_data, lfsr_state;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  lfsr_burst_ctrl #(.CNT_W(8), .DEFAULT_SEED(8'h01)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_seed(cmd_seed), .cmd_reseed(cmd_reseed), .cmd_count(cmd_count),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .lfsr_state(lfsr_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Offer a command in the current (IDLE) cycle and take the accept edge.
  task automatic send_cmd(input logic [7:0] seed, input logic reseed, input logic [7:0] cnt);
    cmd_seed = seed; cmd_reseed = reseed; cmd_count = cnt; cmd_valid = 1'b1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_at_offer got %b want 1", cmd_ready); end
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; tick; tick;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (lfsr_state !== 8'h01) begin fails++; $display("FAIL rst_lfsr got %h want 01", lfsr_state); end
    rst = 1'b1; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rel_cmd_ready got %b want 1", cmd_ready); end
    tests++; if ({out_valid, out_last, busy, done} !== 4'b0000) begin fails++; $display("FAIL rel_flags got %b want 0000", {out_valid, out_last, busy, done}); end
    tests++; if (out_data !== 8'h01) begin fails++; $display("FAIL rel_out_data got %h want 01", out_data); end
    tick;
  endtask

  // Run a burst at full throughput and check each beat, done and re-ready.
  task automatic run_burst(input string nm, input logic [7:0] seed, input logic reseed,
                           input int n, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input logic [7:0] e5, input logic [7:0] e6, input logic [7:0] e7);
    logic [7:0] exp [8];
    exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
    out_ready = 1'b1;
    send_cmd(seed, reseed, 8'(n));
    for (int i = 0; i < n; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_valid[%0d] got %b want 1", nm, i, out_valid); end
      tests++; if (out_data !== exp[i]) begin fails++; $display("FAIL %s_data[%0d] got %h want %h", nm, i, out_data, exp[i]); end
      tests++; if (out_last !== (i == n-1)) begin fails++; $display("FAIL %s_last[%0d] got %b want %b", nm, i, out_last, (i == n-1)); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s_early_done[%0d] got %b want 0", nm, i, done); end
      tick;
    end
    tests++; if ({done, out_valid, cmd_ready} !== 3'b100) begin fails++; $display("FAIL %s_done_cycle got %b want 100", nm, {done, out_valid, cmd_ready}); end
    tick;
    tests++; if ({done, cmd_ready, busy} !== 3'b010) begin fails++; $display("FAIL %s_idle_cycle got %b want 010", nm, {done, cmd_ready, busy}); end
    out_ready = 1'b0;
  endtask

  task automatic test_basic;
    run_burst("basic", 8'h01, 1'b1, 8, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E);
  endtask

  task automatic test_continue;
    run_burst("cont", 8'hFF, 1'b0, 2, 8'h1C, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tests++; if (lfsr_state !== 8'h71) begin fails++; $display("FAIL cont_lfsr_end got %h want 71", lfsr_state); end
  endtask

  task automatic test_zero_seed;
    run_burst("zseed", 8'h00, 1'b1, 3, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [4];
    logic       pat [7];
    int k = 0, hs = 0;
    exp = '{8'h08, 8'h11, 8'h23, 8'h47};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    send_cmd(8'h08, 1'b1, 8'd4);
    for (int c = 0; c < 7; c++) begin
      out_ready = pat[c];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
      tests++; if (out_data !== exp[k]) begin fails++; $display("FAIL bp_data[%0d] got %h want %h", c, out_data, exp[k]); end
      tests++; if (out_last !== (k == 3)) begin fails++; $display("FAIL bp_last[%0d] got %b want %b", c, out_last, (k == 3)); end
      if (out_valid && out_ready) hs++;
      tick;
      if (pat[c]) k++;
    end
    out_ready = 1'b0;
    tests++; if (hs != 4) begin fails++; $display("FAIL bp_handshakes got %0d want 4", hs); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done got %b want 1", done); end
    tests++; if (lfsr_state !== 8'h8E) begin fails++; $display("FAIL bp_lfsr_end got %h want 8E", lfsr_state); end
    tick;
  endtask

  task automatic test_zero_count;
    send_cmd(8'h55, 1'b1, 8'd0);
    tests++; if ({done, out_valid} !== 2'b10) begin fails++; $display("FAIL zc_done_cycle got %b want 10", {done, out_valid}); end
    // Offer another command while in DONE; it must not be taken.
    cmd_seed = 8'hAA; cmd_reseed = 1'b1; cmd_count = 8'd5; cmd_valid = 1'b1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL zc_ready_in_done got %b want 0", cmd_ready); end
    tick;
    cmd_valid = 1'b0;
    tests++; if ({done, out_valid, busy, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL zc_after got %b want 0001", {done, out_valid, busy, cmd_ready}); end
    tests++; if (lfsr_state !== 8'h55) begin fails++; $display("FAIL zc_lfsr got %h want 55", lfsr_state); end
    tick;
    tests++; if ({done, out_valid} !== 2'b00) begin fails++; $display("FAIL zc_quiet got %b want 00", {done, out_valid}); end
  endtask

  task automatic test_abort;
    out_ready = 1'b1;
    send_cmd(8'h01, 1'b1, 8'd10);
    tests++; if (out_data !== 8'h01) begin fails++; $display("FAIL ab_beat0 got %h want 01", out_data); end
    tick;
    tests++; if (out_data !== 8'h02) begin fails++; $display("FAIL ab_beat1 got %h want 02", out_data); end
    tick;
    tests++; if (out_data !== 8'h04) begin fails++; $display("FAIL ab_beat2 got %h want 04", out_data); end
    abort = 1'b1;
    tick;
    abort = 1'b0; out_ready = 1'b0;
    tests++; if ({out_valid, done} !== 2'b01) begin fails++; $display("FAIL ab_end got %b want 01", {out_valid, done}); end
    tests++; if (lfsr_state !== 8'h08) begin fails++; $display("FAIL ab_lfsr got %h want 08", lfsr_state); end
    tick;
    tests++; if ({cmd_ready, done} !== 2'b10) begin fails++; $display("FAIL ab_idle got %b want 10", {cmd_ready, done}); end
    // abort while idle must do nothing.
    abort = 1'b1; tick; abort = 1'b0;
    tests++; if ({cmd_ready, done, busy} !== 3'b100) begin fails++; $display("FAIL ab_idle_ignored got %b want 100", {cmd_ready, done, busy}); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send_cmd(8'h01, 1'b1, 8'd8);
    tick; tick;
    tests++; if (out_data !== 8'h04) begin fails++; $display("FAIL rm_pre got %h want 04", out_data); end
    rst = 1'b0; #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid_low got %b want 0", out_valid); end
    tick;
    tests++; if ({out_valid, done, busy} !== 3'b000) begin fails++; $display("FAIL rm_in_reset got %b want 000", {out_valid, done, busy}); end
    tests++; if (lfsr_state !== 8'h01) begin fails++; $display("FAIL rm_lfsr got %h want 01", lfsr_state); end
    rst = 1'b1; #1;
    tests++; if ({cmd_ready, done, out_valid} !== 3'b100) begin fails++; $display("FAIL rm_release got %b want 100", {cmd_ready, done, out_valid}); end
    tick;
    tests++; if ({cmd_ready, out_valid, out_data} !== {2'b10, 8'h01}) begin fails++; $display("FAIL rm_idle got %b/%b/%h want 1/0/01", cmd_ready, out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_continue;
    test_zero_seed;
    test_backpressure;
    test_zero_count;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
